// File: rtl/mem_load_unit_if.sv
`default_nettype none
// ============================================================================
// mem_load_unit_if
// Request, response and memory-read bundle for the load unit.
// Revision: 1.0
// ============================================================================
interface mem_load_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [2:0]            LoadSrc;

    logic                  mem_rd_en;
    logic [ADDR_WIDTH-3:0] mem_word;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;

    // Driven by the core and the memory model.
    modport master (
        output req_valid, req_addr, LoadSrc, mem_rd_data,
        input  req_ready, mem_rd_en, mem_word, rsp_valid, rsp_data, rsp_err
    );

    // Driven by the load unit.
    modport slave (
        input  req_valid, req_addr, LoadSrc, mem_rd_data,
        output req_ready, mem_rd_en, mem_word, rsp_valid, rsp_data, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_load_unit.sv
`default_nettype none
// ============================================================================
// mem_load_unit
// Load unit: word reads from a synchronous-read memory, lane select and
// sign/zero extension. Define MISALIGNED_EN to merge word-straddling loads
// from two reads; otherwise those loads return an error.
// Revision: 1.0
// ============================================================================
module mem_load_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_SIZE   = 64
) (
    input wire             clk,
    input wire             reset,
    mem_load_unit_if.slave bus
);

    localparam logic [ADDR_WIDTH-3:0] c_mem_size = (ADDR_WIDTH-2)'(MEM_SIZE);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        WT0  = 3'd2,
`ifdef MISALIGNED_EN
        RD1  = 3'd3,
        WT1  = 3'd4,
`endif
        RESP = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_rd_next;

    logic                  r_mem_rd_en;
    logic [ADDR_WIDTH-3:0] r_mem_word;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_err;

    logic [1:0]            r_offset;
    logic [2:0]            r_funct3;

    logic                  w_accept;
    logic                  w_legal;
    logic                  w_split;
    logic                  w_err_req;
    logic [ADDR_WIDTH-3:0] w_word0;

    logic [DATA_WIDTH-1:0]   w_hi;
    logic [DATA_WIDTH-1:0]   w_lo;
    logic [2*DATA_WIDTH-1:0] w_pair;
    logic [DATA_WIDTH-1:0]   w_shifted;
    logic                    w_sext;
    logic [DATA_WIDTH-1:0]   w_result;

    assign bus.req_ready = (r_state == IDLE);
    assign bus.mem_rd_en = r_mem_rd_en;
    assign bus.mem_word  = r_mem_word;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;

    assign w_accept = bus.req_valid && (r_state == IDLE);
    assign w_word0  = bus.req_addr[ADDR_WIDTH-1:2] % c_mem_size;

    // Request decode: legality of the load type and whether it straddles words.
    always_comb begin
        w_legal = 1'b0;
        w_split = 1'b0;
        case (bus.LoadSrc)
            3'b000, 3'b100: w_legal = 1'b1;
            3'b001, 3'b101: begin
                w_legal = 1'b1;
                w_split = (bus.req_addr[1:0] == 2'b11);
            end
            3'b010: begin
                w_legal = 1'b1;
                w_split = (bus.req_addr[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

`ifdef MISALIGNED_EN
    localparam logic [ADDR_WIDTH-3:0] c_last_word = (ADDR_WIDTH-2)'(MEM_SIZE - 1);

    logic                  r_split;
    logic [DATA_WIDTH-1:0] r_lo;
    logic [ADDR_WIDTH-3:0] w_word1;

    assign w_err_req = !w_legal;
    assign w_word1   = (r_mem_word == c_last_word) ? '0 : r_mem_word + 1'b1;
    assign w_hi      = (r_state == WT1) ? bus.mem_rd_data : '0;
    assign w_lo      = (r_state == WT1) ? r_lo : bus.mem_rd_data;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_split <= w_split;
        end
        if (r_state == WT0) begin
            r_lo <= bus.mem_rd_data;
        end
    end
`else
    assign w_err_req = !w_legal || w_split;
    assign w_hi      = '0;
    assign w_lo      = bus.mem_rd_data;
`endif

    // Little-endian lane select over the {hi, lo} pair, then extension.
    assign w_pair    = {w_hi, w_lo};
    assign w_shifted = DATA_WIDTH'(w_pair >> {r_offset, 3'b000});
    assign w_sext    = ~r_funct3[2];

    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_result = {{(DATA_WIDTH-8){w_sext & w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_result = {{(DATA_WIDTH-16){w_sext & w_shifted[15]}}, w_shifted[15:0]};
            default: w_result = w_shifted;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_rd_next    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_err_req) begin
                        w_next_state = RESP;
                    end else begin
                        w_next_state = RD0;
                        w_rd_next    = 1'b1;
                    end
                end
            end
            RD0: w_next_state = WT0;
            WT0: begin
`ifdef MISALIGNED_EN
                if (r_split) begin
                    w_next_state = RD1;
                    w_rd_next    = 1'b1;
                end else begin
                    w_next_state = RESP;
                end
`else
                w_next_state = RESP;
`endif
            end
`ifdef MISALIGNED_EN
            RD1: w_next_state = WT1;
            WT1: w_next_state = RESP;
`endif
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_offset <= bus.req_addr[1:0];
            r_funct3 <= bus.LoadSrc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mem_rd_en <= 1'b0;
            r_mem_word  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_mem_rd_en <= w_rd_next;
            r_rsp_valid <= (w_next_state == RESP);
            if (w_accept) begin
                r_mem_word <= w_word0;
`ifdef MISALIGNED_EN
            end else if ((r_state == WT0) && r_split) begin
                r_mem_word <= w_word1;
`endif
            end
            // Only an error request jumps straight from IDLE to RESP.
            if (w_next_state == RESP) begin
                if (r_state == IDLE) begin
                    r_rsp_err  <= 1'b1;
                    r_rsp_data <= '0;
                end else begin
                    r_rsp_err  <= 1'b0;
                    r_rsp_data <= w_result;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_load_unit.sv
`default_nettype none
// ============================================================================
// tb_mem_load_unit
// Directed vector table plus reset-abort sequence for mem_load_unit.
// Revision: 1.0
// ============================================================================
module tb_mem_load_unit;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] mem [0:63];

    mem_load_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    mem_load_unit #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .MEM_SIZE  (64)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.mem_rd_data <= mem[bus.mem_word];
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          nrd;
        int          w0;
        int          w1;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic [31:0] a, input logic [2:0] f,
                        input logic [31:0] d, input logic e, input int lat,
                        input int nrd, input int w0, input int w1);
        vecs[i].addr = a;   vecs[i].f3  = f;   vecs[i].data = d; vecs[i].err = e;
        vecs[i].lat  = lat; vecs[i].nrd = nrd; vecs[i].w0   = w0; vecs[i].w1  = w1;
    endtask

    task automatic run_load(input logic [31:0] a, input logic [2:0] f,
                            output logic [31:0] d, output logic e, output int lat,
                            output int nrd, output int w0, output int w1);
        lat = 0; nrd = 0; w0 = -1; w1 = -1; d = '0; e = 1'b0;
        @(negedge clk);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.LoadSrc   = f;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (bus.mem_rd_en) begin
                nrd++;
                if (nrd == 1) w0 = int'(bus.mem_word);
                else          w1 = int'(bus.mem_word);
            end
            if (bus.rsp_valid) begin
                lat = k;
                d   = bus.rsp_data;
                e   = bus.rsp_err;
                break;
            end
            @(negedge clk);
        end
        if (lat == 0) begin
            chk("rsp_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            chk("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat, nrd, w0, w1, seen;

        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.LoadSrc   = 3'b000;
        bus.mem_rd_data = '0;

        for (int i = 0; i < 64; i++) mem[i] = 32'h5A5A0000 | i;
        mem[0]  = 32'h01020304;
        mem[1]  = 32'h8899AABB;
        mem[2]  = 32'h11223344;
        mem[63] = 32'hDEADBEEF;

        setv(0,  32'h5,   3'b000, 32'hFFFFFFAA, 1'b0, 3, 1, 1,  -1);
        setv(1,  32'h5,   3'b100, 32'h000000AA, 1'b0, 3, 1, 1,  -1);
        setv(2,  32'h6,   3'b001, 32'hFFFF8899, 1'b0, 3, 1, 1,  -1);
        setv(3,  32'h6,   3'b101, 32'h00008899, 1'b0, 3, 1, 1,  -1);
        setv(4,  32'h4,   3'b010, 32'h8899AABB, 1'b0, 3, 1, 1,  -1);
`ifdef MISALIGNED_EN
        setv(5,  32'h7,   3'b010, 32'h22334488, 1'b0, 5, 2, 1,  2);
        setv(6,  32'hFE,  3'b010, 32'h0304DEAD, 1'b0, 5, 2, 63, 0);
        setv(7,  32'hFF,  3'b001, 32'h000004DE, 1'b0, 5, 2, 63, 0);
`else
        setv(5,  32'h7,   3'b010, 32'h00000000, 1'b1, 1, 0, -1, -1);
        setv(6,  32'hFE,  3'b010, 32'h00000000, 1'b1, 1, 0, -1, -1);
        setv(7,  32'hFF,  3'b001, 32'h00000000, 1'b1, 1, 0, -1, -1);
`endif
        setv(8,  32'h4,   3'b011, 32'h00000000, 1'b1, 1, 0, -1, -1);
        setv(9,  32'h107, 3'b000, 32'hFFFFFF88, 1'b0, 3, 1, 1,  -1);
        setv(10, 32'h102, 3'b101, 32'h00000102, 1'b0, 3, 1, 0,  -1);
        setv(11, 32'h1,   3'b101, 32'h00000203, 1'b0, 3, 1, 0,  -1);
        setv(12, 32'hFD,  3'b001, 32'hFFFFADBE, 1'b0, 3, 1, 63, -1);
        setv(13, 32'h0,   3'b111, 32'h00000000, 1'b1, 1, 0, -1, -1);
        setv(14, 32'h7FC, 3'b100, 32'h000000EF, 1'b0, 3, 1, 63, -1);
        setv(15, 32'hFC,  3'b010, 32'hDEADBEEF, 1'b0, 3, 1, 63, -1);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_rd_en",     32'(bus.mem_rd_en), 32'd0);
        chk("reset_mem_word",  32'(bus.mem_word),  32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_data",  bus.rsp_data,       32'd0);
        chk("reset_rsp_err",   32'(bus.rsp_err),   32'd0);

        for (int i = 0; i < NV; i++) begin
            run_load(vecs[i].addr, vecs[i].f3, d, e, lat, nrd, w0, w1);
            chk($sformatf("v%0d_data", i),  d,         vecs[i].data);
            chk($sformatf("v%0d_err", i),   32'(e),    32'(vecs[i].err));
            chk($sformatf("v%0d_lat", i),   lat,       vecs[i].lat);
            chk($sformatf("v%0d_nrd", i),   nrd,       vecs[i].nrd);
            chk($sformatf("v%0d_word0", i), w0,        vecs[i].w0);
            chk($sformatf("v%0d_word1", i), w1,        vecs[i].w1);
            chk($sformatf("v%0d_hold", i),  bus.rsp_data, vecs[i].data);
        end

        // Reset during WT0 of an aligned lw must abort silently.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h4;
        bus.LoadSrc   = 3'b010;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("abort_rd0_en", 32'(bus.mem_rd_en), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_rd_en",     32'(bus.mem_rd_en), 32'd0);
        chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.mem_rd_en) seen++;
        end
        chk("abort_quiet", seen, 32'd0);

        run_load(32'h4, 3'b100, d, e, lat, nrd, w0, w1);
        chk("post_abort_data",  d,      32'h000000BB);
        chk("post_abort_err",   32'(e), 32'd0);
        chk("post_abort_lat",   lat,    32'd3);
        chk("post_abort_word0", w0,     32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
